debounce_edge_detector: RTL and testbench
=========================================

Name: debounce_edge_detector

Overview:
- Downstream consumer of the d_ff stage. Takes the flop's registered q as its input `din`.
- Filters glitches until the level has been stable for a programmable number of clocks.
- Emits a clean level, single-cycle rise/fall pulses and a wrap-around rise-event counter.
- Used behind button/switch input flops ahead of control logic.

Parameters:
- STABLE_CYCLES, 4, consecutive sampled edges at a new level needed to accept it; legal range 2..65535.
- CNT_W, 8, width of event_count.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  already-registered bit from the d_ff stage (same clk domain); no extra synchronizer inside.
- clr_count  input  1  synchronous clear of event_count.
- level  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when level goes 0->1, registered.
- fall  output  1  one-cycle pulse when level goes 1->0, registered.
- event_count  output  CNT_W  number of accepted rises, wraps modulo 2^CNT_W.
- glitch_count  output  8  rejected-transition counter (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high; ports named clk and rst.
  - rst sampled high at a clk edge forces: state=S_LOW, stab_cnt=0, level=0, rise=0, fall=0, event_count=0, glitch_count=0.
  - rst has priority over every other input.
  - Reset mid-debounce discards the partial count; no pulse is produced.
- FSM states, with stab_cnt of width clog2(STABLE_CYCLES):
  - S_LOW: level=0. din=1 -> S_CHK_HIGH, stab_cnt=1. Otherwise stay.
  - S_CHK_HIGH: level=0.
    - din=0 -> S_LOW, stab_cnt=0 (glitch reject).
    - din=1 and stab_cnt==STABLE_CYCLES-1 -> S_HIGH, level=1, rise=1, stab_cnt=0.
    - din=1 otherwise -> stab_cnt+1.
  - S_HIGH: level=1. din=0 -> S_CHK_LOW, stab_cnt=1. Otherwise stay.
  - S_CHK_LOW: mirror of S_CHK_HIGH.
    - din=1 -> S_HIGH (glitch reject).
    - Terminal count -> S_LOW, level=0, fall=1.
- Latency:
  - level and rise/fall update at the STABLE_CYCLES-th consecutive edge at which din is sampled at the new value.
  - Edges counted from the first edge with rst=0.
- Pulses:
  - rise and fall are high for exactly one cycle, otherwise 0.
  - rise and fall are never high together.
  - Minimum spacing between a rise and the following fall is STABLE_CYCLES cycles.
- event_count:
  - Increments by 1 on the same edge rise is set.
  - Wraps from 2^CNT_W-1 to 0.
  - clr_count alone sets it to 0.
  - clr_count coincident with an accepted rise sets it to 1.
  - clr_count has no effect on level, pulses or FSM.
- din held constant: no state change, no pulses, counters hold.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - glitch_count increments on every reject transition (S_CHK_HIGH->S_LOW or S_CHK_LOW->S_HIGH).
  - Saturates at 255.
  - Cleared by rst and by clr_count.
- Not defined:
  - No glitch counter logic is synthesized.
  - glitch_count is tied to 0.

Test Plan:
- Defaults (STABLE_CYCLES=4, CNT_W=8).
  - rst=1 for 3 edges with din=1 -> level=0, rise=0, event_count=0.
  - Then rst=0, din held 1 -> rise=1 and level=1 at the 4th edge after rst drop; rise=0 the next cycle; event_count=1.
- din=1 for 3 edges, then 0.
  - -> level stays 0, no rise.
  - With DEBOUNCE_GLITCH_CNT_EN: glitch_count=1. Without it: 0.
- Clean press/release: din=1 for 10 edges, then din=0 for 10 edges.
  - -> one rise pulse, then a fall pulse at the 4th low edge.
  - level tracks accordingly; event_count=1.
- CNT_W=3 variant: 8 clean presses -> event_count steps 1..7 then 0.
- clr_count=1 on the same edge as an accepted rise, with event_count=5 -> event_count=1.
- rst=1 while in S_CHK_HIGH (stab_cnt=2), din kept 1.
  - -> no rise during or after the reset edge.
  - rise appears only at the 4th edge after rst deasserts.

Source files
------------

// File: rtl/debounce_edge_detector.sv
// Debounces a registered 1-bit input and emits a clean level, rise/fall pulses and a rise counter.
// Optional macro DEBOUNCE_GLITCH_CNT_EN enables a saturating rejected-transition counter.
module debounce_edge_detector #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             clr_count,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] event_count,
   output logic [7:0]       glitch_count
);

   localparam int STAB_W = $clog2(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
   localparam logic [CNT_W-1:0]  EVT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [STAB_W-1:0]   stab_cnt_r;
   logic [STAB_W-1:0]   stab_cnt_s;
   logic                level_s;
   logic                rise_s;
   logic                fall_s;

   // Next-state, stability count and next registered outputs
   always_comb begin
      state_s    = state_r;
      stab_cnt_s = stab_cnt_r;
      level_s    = level;
      rise_s     = 1'b0;
      fall_s     = 1'b0;
      case (state_r)
         S_LOW: begin
            level_s = 1'b0;
            if (din) begin
               state_s    = S_CHK_HIGH;
               stab_cnt_s = STAB_ONE;
            end else begin
               stab_cnt_s = '0;
            end
         end
         S_CHK_HIGH: begin
            level_s = 1'b0;
            if (!din) begin
               state_s    = S_LOW;
               stab_cnt_s = '0;
            end else if (stab_cnt_r == STAB_LAST) begin
               state_s    = S_HIGH;
               stab_cnt_s = '0;
               level_s    = 1'b1;
               rise_s     = 1'b1;
            end else begin
               stab_cnt_s = stab_cnt_r + STAB_ONE;
            end
         end
         S_HIGH: begin
            level_s = 1'b1;
            if (!din) begin
               state_s    = S_CHK_LOW;
               stab_cnt_s = STAB_ONE;
            end else begin
               stab_cnt_s = '0;
            end
         end
         S_CHK_LOW: begin
            level_s = 1'b1;
            if (din) begin
               state_s    = S_HIGH;
               stab_cnt_s = '0;
            end else if (stab_cnt_r == STAB_LAST) begin
               state_s    = S_LOW;
               stab_cnt_s = '0;
               level_s    = 1'b0;
               fall_s     = 1'b1;
            end else begin
               stab_cnt_s = stab_cnt_r + STAB_ONE;
            end
         end
         default: begin
            state_s    = S_LOW;
            stab_cnt_s = '0;
            level_s    = 1'b0;
         end
      endcase
   end

   // State register and registered level/pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_LOW;
         stab_cnt_r <= '0;
         level      <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         state_r    <= state_s;
         stab_cnt_r <= stab_cnt_s;
         level      <= level_s;
         rise       <= rise_s;
         fall       <= fall_s;
      end
   end

   // Rise counter; an accepted rise beats a coincident clear so the count lands on 1
   always_ff @(posedge clk) begin
      if (rst) begin
         event_count <= '0;
      end else if (rise_s) begin
         event_count <= clr_count ? EVT_ONE : (event_count + EVT_ONE);
      end else if (clr_count) begin
         event_count <= '0;
      end else begin
         event_count <= event_count;
      end
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic reject_s;
   assign reject_s = ((state_r == S_CHK_HIGH) && !din) || ((state_r == S_CHK_LOW) && din);

   // Saturating count of transitions abandoned before reaching stability
   always_ff @(posedge clk) begin
      if (rst || clr_count) begin
         glitch_count <= 8'd0;
      end else if (reject_s && (glitch_count != 8'd255)) begin
         glitch_count <= glitch_count + 8'd1;
      end else begin
         glitch_count <= glitch_count;
      end
   end
`else
   assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Directed, table-driven bench for debounce_edge_detector (default and CNT_W=3 instances).
`timescale 1ns/1ps
module tb_debounce_edge_detector;

   logic       clk = 1'b0;
   logic       rst, din, clr_count;
   logic       level, rise, fall;
   logic [7:0] event_count, glitch_count;
   logic       level3, rise3, fall3;
   logic [2:0] event_count3;
   logic [7:0] glitch_count3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   debounce_edge_detector #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .clr_count(clr_count),
      .level(level), .rise(rise), .fall(fall),
      .event_count(event_count), .glitch_count(glitch_count));

   debounce_edge_detector #(.STABLE_CYCLES(4), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .din(din), .clr_count(clr_count),
      .level(level3), .rise(rise3), .fall(fall3),
      .event_count(event_count3), .glitch_count(glitch_count3));

   typedef struct {
      logic       r;
      logic       d;
      logic       c;
      logic       level;
      logic       rise;
      logic       fall;
      logic [7:0] cnt;
      logic [7:0] glitch;
   } vec_t;

   function automatic logic [7:0] gexp(input logic [7:0] g);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      return g;
`else
      return 8'd0 & g;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic d, input logic c, input logic r);
      din = d; clr_count = c; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int exp_cnt, input logic clr_at_rise);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         check("press_no_early_rise", {31'd0, rise}, 32'd0);
      end
      tick(1'b1, clr_at_rise, 1'b0);
      check("press_rise", {31'd0, rise}, 32'd1);
      check("press_level", {31'd0, level}, 32'd1);
      check("press_cnt8", {24'd0, event_count}, exp_cnt & 32'hFF);
      check("press_cnt3", {29'd0, event_count3}, exp_cnt & 32'h7);
      tick(1'b1, 1'b0, 1'b0);
      check("press_rise_one_cycle", {31'd0, rise}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         check("release_level_held", {30'd0, level, fall}, 32'd2);
      end
      tick(1'b0, 1'b0, 1'b0);
      check("release_fall", {30'd0, level, fall}, 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      check("release_fall_one_cycle", {31'd0, fall}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      rst = 1'b1; din = 1'b1; clr_count = 1'b0;
      // {rst, din, clr, level, rise, fall, event_count, glitch_raw}
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0});
      // three-edge high glitch is rejected
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].d, vecs[i].c, vecs[i].r);
         check($sformatf("vec%0d_level", i), {31'd0, level}, {31'd0, vecs[i].level});
         check($sformatf("vec%0d_rise", i), {31'd0, rise}, {31'd0, vecs[i].rise});
         check($sformatf("vec%0d_fall", i), {31'd0, fall}, {31'd0, vecs[i].fall});
         check($sformatf("vec%0d_cnt", i), {24'd0, event_count}, {24'd0, vecs[i].cnt});
         check($sformatf("vec%0d_glitch", i), {24'd0, glitch_count}, {24'd0, gexp(vecs[i].glitch)});
      end

      // Wrap test: both instances see 8 clean presses
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) press(i, 1'b0);
      check("wrap_cnt3_zero", {29'd0, event_count3}, 32'd0);
      check("wrap_cnt8_eight", {24'd0, event_count}, 32'd8);

      // Clear alone, then clear coincident with rise at count 5
      tick(1'b0, 1'b1, 1'b0);
      check("clr_alone", {24'd0, event_count}, 32'd0);
      for (int i = 1; i <= 5; i++) press(i, 1'b0);
      check("cnt_five", {24'd0, event_count}, 32'd5);
      press(1, 1'b1);

      // Reset in S_CHK_HIGH with stab_cnt=2
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      check("midrst_rise", {31'd0, rise}, 32'd0);
      check("midrst_level", {31'd0, level}, 32'd0);
      check("midrst_cnt", {24'd0, event_count}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         check("postrst_no_rise", {31'd0, rise}, 32'd0);
      end
      tick(1'b1, 1'b0, 1'b0);
      check("postrst_rise_4th", {31'd0, rise}, 32'd1);
      check("postrst_cnt", {24'd0, event_count}, 32'd1);

      // Low-going glitch while high is rejected
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      check("lowglitch_level", {30'd0, level, fall}, 32'd2);
      check("lowglitch_count", {24'd0, glitch_count}, {24'd0, gexp(8'd1)});
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0);
      check("hold_level", {29'd0, level, rise, fall}, 32'd4);
      check("hold_cnt", {24'd0, event_count}, 32'd1);
      check("hold_glitch", {24'd0, glitch_count}, {24'd0, gexp(8'd1)});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Rise and fall must never coincide
   always @(negedge clk) begin
      if (rise && fall) begin
         errors++;
         $display("FAIL rise_fall_overlap: rise=%0b fall=%0b expected not both", rise, fall);
      end
   end

endmodule
